inst_fetch: RTL and testbench

//  Instruction-fetch stage feeding the IF/ID pipeline register. Holds the PC, serves

---
 rtl/inst_fetch.sv | 113 +++++++++++
 tb/tb_inst_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC register, direct-mapped one-word-per-line I-cache,
// and a single-outstanding refill handshake with the memory controller.
module inst_fetch #(
  parameter int unsigned IDX_W    = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_interception,
  input  logic [31:0] branch_target,
  input  logic        ifid_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int unsigned LINES = 2 ** IDX_W;
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {
    S_RUN,
    S_WAIT
  } state_t;

  state_t            state, state_next;
  logic [31:0]       pc, pc_next;
  logic [31:0]       mem_addr_next;
  logic              discard, discard_next;
  logic              fill_en;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_ram  [LINES];
  logic [31:0]       data_ram [LINES];

  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  fill_idx;
  logic              hit;

  assign idx      = pc[IDX_W+1:2];
  assign fill_idx = mem_addr[IDX_W+1:2];
  assign hit      = valid[idx] && (tag_ram[idx] == pc[31:IDX_W+2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RUN;
      pc       <= RESET_PC;
      mem_addr <= '0;
      discard  <= 1'b0;
      valid    <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      mem_addr <= mem_addr_next;
      discard  <= discard_next;
      if (fill_en) begin
        valid[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data arrays need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_ram[fill_idx]  <= mem_addr[31:IDX_W+2];
      data_ram[fill_idx] <= mem_rdata;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    mem_addr_next = mem_addr;
    discard_next  = discard;
    fill_en       = 1'b0;
    case (state)
      S_RUN: begin
        if (branch_interception) begin
          pc_next = branch_target;
        end else if (!hit) begin
          state_next    = S_WAIT;
          mem_addr_next = {pc[31:2], 2'b00};
        end else if (!ifid_stall) begin
          pc_next = pc + 32'd4;
        end
      end
      S_WAIT: begin
        // The outstanding refill is never aborted; a redirect only moves the PC.
        if (mem_done) begin
          fill_en      = 1'b1;
          state_next   = S_RUN;
          discard_next = 1'b0;
          if (branch_interception) begin
            pc_next = branch_target;
          end
        end else if (branch_interception) begin
          pc_next      = branch_target;
          discard_next = 1'b1;
        end
      end
      default: state_next = S_RUN;
    endcase
  end

  always_comb begin
    mem_req = (state == S_WAIT);
    if_pc   = pc;
    if_inst = ((state == S_RUN) && hit) ? data_ram[idx] : '0;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized scoreboard bench for inst_fetch: a cycle-level reference model pushes the
// expected outputs per cycle and an independent monitor pops and compares them.
module tb_inst_fetch;

  localparam int unsigned IDX_W    = 6;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned NCYC     = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_interception;
  logic [31:0] branch_target;
  logic        ifid_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  inst_fetch #(.IDX_W(IDX_W), .RESET_PC(RESET_PC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .branch_interception (branch_interception),
    .branch_target       (branch_target),
    .ifid_stall          (ifid_stall),
    .mem_req             (mem_req),
    .mem_addr            (mem_addr),
    .mem_done            (mem_done),
    .mem_rdata           (mem_rdata),
    .if_pc               (if_pc),
    .if_inst             (if_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        req;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: the cache is a map from line index to the word address it holds.
  bit [31:0]   m_pc;
  bit          m_wait;
  bit [31:0]   m_addr;
  bit [31:0]   line_addr [int unsigned];

  function automatic bit [31:0] memword(bit [31:0] a);
    return (a * 32'h9E37_79B1) | 32'h1;
  endfunction

  function automatic int unsigned line_of(bit [31:0] a);
    return (a >> 2) % (2 ** IDX_W);
  endfunction

  function automatic bit model_hit();
    int unsigned l = line_of(m_pc);
    return line_addr.exists(l) && (line_addr[l] == m_pc);
  endfunction

  function automatic void model_reset();
    m_pc   = RESET_PC;
    m_wait = 1'b0;
    m_addr = '0;
    line_addr.delete();
  endfunction

  function automatic void model_step(bit br, bit [31:0] tgt, bit stall, bit done);
    if (!m_wait) begin
      if (br)              m_pc = tgt;
      else if (!model_hit()) begin m_wait = 1'b1; m_addr = m_pc; end
      else if (!stall)     m_pc = m_pc + 32'd4;
    end else begin
      if (done) begin
        line_addr[line_of(m_addr)] = m_addr;
        m_wait = 1'b0;
      end
      if (br) m_pc = tgt;
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.pc   = m_pc;
    e.inst = (!m_wait && model_hit()) ? memword(m_pc) : 32'h0;
    e.req  = m_wait;
    e.addr = m_addr;
    exp_q.push_back(e);
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Monitor: one expected snapshot per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty cyc=%0d got=0 want=1", cyc);
      end else begin
        e = exp_q.pop_front();
        check("if_pc",    if_pc,            e.pc);
        check("if_inst",  if_inst,          e.inst);
        check("mem_req",  {31'b0, mem_req}, {31'b0, e.req});
        check("mem_addr", mem_addr,         e.addr);
      end
    end
  end

  // Stimulus + memory responder, driven just after the falling edge.
  initial begin
    int unsigned lat = 0;
    bit          did_reset = 1'b0;
    bit          br, stall, done;
    bit [31:0]   tgt;

    rst = 1'b1; branch_interception = 1'b0; branch_target = '0;
    ifid_stall = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    model_reset();
    push_exp();

    for (int unsigned i = 0; i < NCYC; i++) begin
      @(negedge clk);
      #1;
      rst = 1'b0;

      if (!did_reset && i > 1500 && m_wait) begin
        rst = 1'b1;
        #1;
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_if_pc",   if_pc,            RESET_PC);
        check("rst_if_inst", if_inst,          32'h0);
        #1;
        rst = 1'b0;
        model_reset();
        lat = 0;
        did_reset = 1'b1;
      end

      if (i < 60) begin
        br = 1'b0; stall = 1'b0;
      end else if (i == 60) begin
        br = 1'b1; stall = 1'b0;
      end else if (i < 80) begin
        br = 1'b0; stall = 1'b0;
      end else begin
        br    = ($urandom_range(0, 9) == 0);
        stall = ($urandom_range(0, 3) == 0);
      end
      if (i == 60)                            tgt = 32'h0;
      else if ($urandom_range(0, 15) == 0)    tgt = 32'hFFFF_FFF8;
      else                                    tgt = {22'b0, 8'($urandom_range(0, 255)), 2'b00};

      if (m_wait) begin
        if (lat == 0) lat = $urandom_range(1, 4);
        lat--;
        done = (lat == 0);
        mem_rdata = done ? memword(m_addr) : $urandom;
      end else begin
        done = (i >= 80) && ($urandom_range(0, 15) == 0);
        mem_rdata = $urandom;
      end

      branch_interception = br;
      branch_target       = tgt;
      ifid_stall          = stall;
      mem_done            = done;
      model_step(br, tgt, stall, done);
      push_exp();
    end

    @(negedge clk);
    #2;
    if (!did_reset) begin
      total++;
      bad++;
      $display("FAIL reset_in_wait got=0 want=1");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
